// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int WORD_BYTES     = 4;
    localparam int PC_READ_OFFSET = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_FLUSH
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with push/pop/flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [31:0]              wpc_i,
    input  logic [31:0]              winstr_i,
    output logic [31:0]              rpc_o,
    output logic [31:0]              rinstr_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    // Flush voids any same-cycle push or pop.
    assign do_push = push_i & !flush_i;
    assign do_pop  = pop_i & !empty_o & !flush_i;

    assign count_o  = count_q;
    assign full_o   = (count_q == (PW+1)'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign rpc_o    = mem_q[rd_ptr_q].pc;
    assign rinstr_o = mem_q[rd_ptr_q].instr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= rd_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= '{pc: wpc_i, instr: winstr_i};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ARM instruction fetch stage: credit-limited memory reads into a prefetch queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus8
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_full, fifo_empty;
    logic [31:0]   head_pc, head_instr, target_pc;
    logic          issue, resp, accept, byp, push, pop;
    logic          unused_pc_lsbs;

    assign target_pc      = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    // Queued plus in-flight words never exceed DEPTH, so a response always has room.
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req    = (state_q != S_BOOT) && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc_q;

    assign issue  = imem_req & imem_gnt;
    assign resp   = imem_rvalid & (outstanding_q != '0);
    assign accept = resp & (discard_q == '0) & !redirect;

`ifdef FETCH_BYPASS_EN
    assign byp = accept & fifo_empty;
`else
    assign byp = 1'b0;
`endif

    assign push = accept & !(byp & instr_ready);
    assign pop  = !fifo_empty & instr_ready & !redirect;

    assign instr_valid   = byp | !fifo_empty;
    assign instr         = byp ? imem_rdata : head_instr;
    assign instr_pc      = byp ? resp_pc_q  : head_pc;
    assign instr_pcplus8 = instr_pc + 32'(PC_READ_OFFSET);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .push_i   (push),
        .pop_i    (pop),
        .flush_i  (redirect),
        .wpc_i    (resp_pc_q),
        .winstr_i (imem_rdata),
        .rpc_o    (head_pc),
        .rinstr_o (head_instr),
        .count_o  (fifo_count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_comb begin
        outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        if (redirect) begin
            // Everything still in flight after this edge belongs to the old stream.
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            discard_d  = outstanding_d;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
            if (resp && (discard_q != '0)) discard_d = discard_q - CW'(1);
            if (accept) resp_pc_d = resp_pc_q + 32'(WORD_BYTES);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   if (redirect && (outstanding_d != '0)) state_d = S_FLUSH;
            S_FLUSH: if (discard_d == '0) state_d = S_RUN;
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && fifo_full));
    a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (outstanding_q != '0));

endmodule
